// File: rtl/cdf_accumulator_if.sv
// Bus bundle for the CDF accumulator: histogram RAM read port plus the
// divider-side handshake.
//
// Handshake: cdf_valid is a one-cycle offer of cdf_out/bin_idx. The offer
// stays pending, with cdf_out and bin_idx held, until ds_done is sampled high
// on a rising clock edge. ds_done is ignored while no offer is pending.
// hist_data must carry mem[hist_addr] exactly one cycle after hist_rd.
interface cdf_accumulator_if #(
  parameter int CNT_W = 19
);
  logic             hist_rd;
  logic [7:0]       hist_addr;
  logic [CNT_W-1:0] hist_data;
  logic [7:0]       cdf_out;
  logic             cdf_valid;
  logic             ds_done;
  logic [7:0]       bin_idx;

  // Accumulator side: reads the RAM, offers results to the divider
  modport master (
    output hist_rd, hist_addr, cdf_out, cdf_valid, bin_idx,
    input  hist_data, ds_done
  );

  // RAM / divider side
  modport slave (
    input  hist_rd, hist_addr, cdf_out, cdf_valid, bin_idx,
    output hist_data, ds_done
  );
endinterface

// File: rtl/cdf_accumulator.sv
// CDF accumulator for histogram equalisation.
// Walks 256 histogram bins in order, keeps a running sum and offers each
// scaled cumulative value (acc_eff >> SHIFT, saturated to 8 bits) to the
// divider, advancing one bin per divider handshake.
// Optional feature macro: CDF_MIN_EN -- subtract the cumulative value of the
// first non-zero bin (cdf_min) before scaling.
module cdf_accumulator #(
  parameter int CNT_W = 19,
  parameter int SHIFT = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  cdf_accumulator_if.master     bus,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state_dbg
);

  localparam int ACC_W = CNT_W + 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_ACC     = 3'd2,
    S_SEND    = 3'd3,
    S_WAIT_DS = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [7:0]         k;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_nxt;
  logic [ACC_W-1:0]   acc_eff;
  logic [ACC_W-1:0]   scaled_full;
  logic [7:0]         cdf_scaled;
  logic [7:0]         cdf_out_r;
  logic [7:0]         bin_idx_r;
  logic               hs_done;
  logic               hist_rd_c;
  logic               cdf_valid_c;

  assign acc_nxt = acc + ACC_W'(bus.hist_data);
  assign hs_done = ((state == S_SEND) || (state == S_WAIT_DS)) && bus.ds_done;

`ifdef CDF_MIN_EN
  logic [ACC_W-1:0] cdf_min;
  logic [ACC_W-1:0] cdf_min_nxt;
  logic             min_vld;
  logic             min_vld_nxt;

  // Capture the running sum at the first non-zero bin and offset from it
  always_comb begin
    cdf_min_nxt = cdf_min;
    min_vld_nxt = min_vld;
    if (!min_vld && (bus.hist_data != '0)) begin
      cdf_min_nxt = acc_nxt;
      min_vld_nxt = 1'b1;
    end
    acc_eff = min_vld_nxt ? (acc_nxt - cdf_min_nxt) : '0;
  end

  // cdf_min register: cleared on start, updated once per bin in ACC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cdf_min <= '0;
      min_vld <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      cdf_min <= '0;
      min_vld <= 1'b0;
    end else if (state == S_ACC) begin
      cdf_min <= cdf_min_nxt;
      min_vld <= min_vld_nxt;
    end
  end
`else
  assign acc_eff = acc_nxt;
`endif

  // Scale and saturate the effective sum to 8 bits
  always_comb begin
    scaled_full = acc_eff >> SHIFT;
    cdf_scaled  = (scaled_full > ACC_W'(255)) ? 8'hFF : scaled_full[7:0];
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and strobe outputs
  always_comb begin
    state_nxt   = state;
    hist_rd_c   = 1'b0;
    cdf_valid_c = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RD;
      end
      S_RD: begin
        hist_rd_c = 1'b1;
        busy      = 1'b1;
        state_nxt = S_ACC;
      end
      S_ACC: begin
        busy      = 1'b1;
        state_nxt = S_SEND;
      end
      S_SEND: begin
        cdf_valid_c = 1'b1;
        busy        = 1'b1;
        if (hs_done) state_nxt = (k == 8'd255) ? S_DONE : S_RD;
        else         state_nxt = S_WAIT_DS;
      end
      S_WAIT_DS: begin
        busy = 1'b1;
        if (hs_done) state_nxt = (k == 8'd255) ? S_DONE : S_RD;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: bin counter, accumulator and held divider operands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k         <= '0;
      acc       <= '0;
      cdf_out_r <= '0;
      bin_idx_r <= '0;
    end else begin
      if ((state == S_IDLE) && start) begin
        k   <= '0;
        acc <= '0;
      end
      if (state == S_ACC) begin
        acc       <= acc_nxt;
        cdf_out_r <= cdf_scaled;
        bin_idx_r <= k;
      end
      if (hs_done && (k != 8'd255)) k <= k + 8'd1;
    end
  end

  assign bus.hist_rd   = hist_rd_c;
  assign bus.hist_addr = k;
  assign bus.cdf_valid = cdf_valid_c;
  assign bus.cdf_out   = cdf_out_r;
  assign bus.bin_idx   = bin_idx_r;
  assign state_dbg     = state;

endmodule

// File: tb/tb_cdf_accumulator.sv
// Bench for cdf_accumulator: behavioural RAM, randomised divider responder,
// bus monitor and a reference model of the cumulative-sum scaling.
module tb_cdf_accumulator;
  localparam int CNT_W  = 19;
  localparam int SHIFT  = 10;
  localparam int BUDGET = 20000;

  logic       clk;
  logic       reset;
  logic       start;
  logic       busy;
  logic       done;
  logic [2:0] state_dbg;

  cdf_accumulator_if #(.CNT_W(CNT_W)) bus ();

  cdf_accumulator #(.CNT_W(CNT_W), .SHIFT(SHIFT)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  logic [CNT_W-1:0] mem [256];
  logic [7:0]       exp_q [$];
  logic [7:0]       obs_cdf [$];
  logic [7:0]       obs_bin [$];
  logic [7:0]       rd_q [$];
  int               done_cnt = 0;
  int               ds_mode = 0;   // 0: ds_done high, 1: fixed 5-cycle delay, 2: random delay
  int               ds_lat;
  logic             pending;
  logic [7:0]       held_cdf;
  logic [7:0]       held_bin;
  logic             rd_s;
  logic [7:0]       addr_s;

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
  end

  // Histogram RAM: data one cycle after the read strobe, junk otherwise
  initial begin
    bus.hist_data = '0;
    forever begin
      @(negedge clk);
      rd_s   = bus.hist_rd;
      addr_s = bus.hist_addr;
      @(posedge clk);
      #1;
      bus.hist_data = rd_s ? mem[addr_s] : CNT_W'($urandom);
    end
  end

  // Divider responder
  initial begin
    bus.ds_done = 1'b0;
    forever begin
      @(negedge clk);
      if (ds_mode == 0) bus.ds_done = 1'b1;
      else if (bus.cdf_valid && !reset) begin
        ds_lat = (ds_mode == 1) ? 5 : $urandom_range(0, 6);
        bus.ds_done = 1'b0;
        repeat (ds_lat) @(negedge clk);
        bus.ds_done = 1'b1;
        @(negedge clk);
        bus.ds_done = 1'b0;
      end else begin
        bus.ds_done = (ds_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  // Monitor: records offers and reads, checks operands are held while waiting
  initial begin
    pending = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) pending = 1'b0;
      else begin
        if (pending) begin
          checks++;
          if (bus.cdf_valid !== 1'b0 || bus.hist_rd !== 1'b0 ||
              bus.cdf_out !== held_cdf || bus.bin_idx !== held_bin) begin
            errors++;
            $display("FAIL wait_hold valid=%0b rd=%0b cdf=%0d exp=%0d idx=%0d exp=%0d",
                     bus.cdf_valid, bus.hist_rd, bus.cdf_out, held_cdf, bus.bin_idx, held_bin);
          end
        end else if (bus.cdf_valid) begin
          obs_cdf.push_back(bus.cdf_out);
          obs_bin.push_back(bus.bin_idx);
          held_cdf = bus.cdf_out;
          held_bin = bus.bin_idx;
          pending  = 1'b1;
        end
        if (pending && bus.ds_done) pending = 1'b0;
        if (bus.hist_rd) rd_q.push_back(bus.hist_addr);
        if (done) done_cnt++;
      end
    end
  end

  // Reference model: cumulative sum per bin, optional first-non-zero offset
  function automatic void build_expected();
    longint acc;
    longint minv;
    longint eff;
    longint v;
    bit     got;
    exp_q.delete();
    acc  = 0;
    minv = 0;
    got  = 0;
    for (int b = 0; b < 256; b++) begin
      acc += longint'(mem[b]);
`ifdef CDF_MIN_EN
      if (!got && mem[b] != 0) begin
        got  = 1;
        minv = acc;
      end
      eff = got ? acc - minv : 0;
`else
      eff = acc;
`endif
      v = eff >> SHIFT;
      exp_q.push_back((v > 255) ? 8'd255 : v[7:0]);
    end
  endfunction

  // Scoreboard: count bins whose offer or read address differs from the model
  function automatic int score_pass(output int first_bin, output logic [7:0] got_v,
                                    output logic [7:0] exp_v);
    int mism = 0;
    first_bin = -1;
    got_v = '0;
    exp_v = '0;
    for (int i = 0; i < 256; i++) begin
      if (i >= obs_cdf.size() || i >= rd_q.size()) mism++;
      else if (obs_cdf[i] !== exp_q[i] || obs_bin[i] !== 8'(i) || rd_q[i] !== 8'(i)) mism++;
      if (mism != 0 && first_bin < 0) begin
        first_bin = i;
        exp_v = exp_q[i];
        if (i < obs_cdf.size()) got_v = obs_cdf[i];
      end
    end
    return mism;
  endfunction

  // Driver: one pass, optional re-start or reset at a given bin offer
  task automatic run_pass(input int restart_bin, input int abort_bin,
                          output int cycles, output bit got_done);
    bit restarted = 0;
    obs_cdf.delete();
    obs_bin.delete();
    rd_q.delete();
    done_cnt = 0;
    @(negedge clk);
    start    = 1'b1;
    cycles   = 0;
    got_done = 0;
    while (cycles < BUDGET && !got_done) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      cycles++;
      if (done) got_done = 1;
      else if (restart_bin >= 0 && !restarted && bus.cdf_valid && bus.bin_idx == 8'(restart_bin)) begin
        start     = 1'b1;
        restarted = 1;
      end else if (abort_bin >= 0 && bus.cdf_valid && bus.bin_idx == 8'(abort_bin)) begin
        reset = 1'b1;
        #1;
        return;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    ds_mode = 2;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({bus.hist_rd, bus.hist_addr, bus.cdf_out, bus.cdf_valid, bus.bin_idx, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs rd=%0b addr=%0d cdf=%0d valid=%0b idx=%0d busy=%0b done=%0b exp=all0",
               bus.hist_rd, bus.hist_addr, bus.cdf_out, bus.cdf_valid, bus.bin_idx, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if ({bus.hist_rd, bus.cdf_valid, busy, done} !== 4'b0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL idle_ignores_ds_done rd=%0b valid=%0b busy=%0b done=%0b reads=%0d exp=0",
               bus.hist_rd, bus.cdf_valid, busy, done, rd_q.size());
    end
  endtask

  task automatic test_uniform();
    int cyc; bit gd; int mism; int fb; logic [7:0] g; logic [7:0] e;
    for (int i = 0; i < 256; i++) mem[i] = CNT_W'(1024);
    build_expected();
    ds_mode = 0;
    run_pass(-1, -1, cyc, gd);
    checks++;
    if (!gd || cyc != 769) begin
      errors++;
      $display("FAIL uniform_latency done=%0b cycles=%0d exp=769", gd, cyc);
    end
    checks++;
    if (obs_cdf.size() != 256 || done_cnt != 1) begin
      errors++;
      $display("FAIL uniform_counts valids=%0d done=%0d exp=256/1", obs_cdf.size(), done_cnt);
    end
    mism = score_pass(fb, g, e);
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL uniform_cdf mismatches=%0d first_bin=%0d got=%0d exp=%0d", mism, fb, g, e);
    end
    checks++;
    if (obs_cdf.size() == 256 &&
        (obs_cdf[0] !== 8'd1 || obs_cdf[99] !== 8'd100 || obs_cdf[254] !== 8'd255 || obs_cdf[255] !== 8'd255)) begin
      errors++;
      $display("FAIL uniform_points got=%0d,%0d,%0d,%0d exp=1,100,255,255",
               obs_cdf[0], obs_cdf[99], obs_cdf[254], obs_cdf[255]);
    end
  endtask

  task automatic test_ds_delay();
    int cyc; bit gd; int mism; int fb; logic [7:0] g; logic [7:0] e;
    for (int i = 0; i < 256; i++) mem[i] = CNT_W'(1024);
    build_expected();
    ds_mode = 1;
    run_pass(-1, -1, cyc, gd);
    checks++;
    if (!gd || cyc != 2049) begin
      errors++;
      $display("FAIL ds_delay_latency done=%0b cycles=%0d exp=2049", gd, cyc);
    end
    mism = score_pass(fb, g, e);
    checks++;
    if (mism != 0 || obs_cdf.size() != 256 || done_cnt != 1) begin
      errors++;
      $display("FAIL ds_delay_cdf mismatches=%0d first_bin=%0d got=%0d exp=%0d valids=%0d done=%0d",
               mism, fb, g, e, obs_cdf.size(), done_cnt);
    end
  endtask

  task automatic test_sparse();
    int cyc; bit gd; int mism; int fb; logic [7:0] g; logic [7:0] e;
    logic [7:0] e10; logic [7:0] e11;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[10] = CNT_W'(2048);
    mem[11] = CNT_W'(1024);
`ifdef CDF_MIN_EN
    e10 = 8'd0; e11 = 8'd1;
`else
    e10 = 8'd2; e11 = 8'd3;
`endif
    build_expected();
    ds_mode = 2;
    run_pass(-1, -1, cyc, gd);
    mism = score_pass(fb, g, e);
    checks++;
    if (!gd || mism != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL sparse_cdf done=%0b mismatches=%0d first_bin=%0d got=%0d exp=%0d", gd, mism, fb, g, e);
    end
    checks++;
    if (obs_cdf.size() != 256 || obs_cdf[9] !== 8'd0 || obs_cdf[10] !== e10 ||
        obs_cdf[11] !== e11 || obs_cdf[255] !== e11) begin
      errors++;
      $display("FAIL sparse_points valids=%0d got=%0d,%0d,%0d,%0d exp=0,%0d,%0d,%0d",
               obs_cdf.size(), obs_cdf[9], obs_cdf[10], obs_cdf[11], obs_cdf[255], e10, e11, e11);
    end
  endtask

  task automatic test_reset_mid();
    int cyc; bit gd; int mism; int fb; logic [7:0] g; logic [7:0] e;
    for (int i = 0; i < 256; i++) mem[i] = CNT_W'(1024);
    build_expected();
    ds_mode = 0;
    run_pass(-1, 100, cyc, gd);
    checks++;
    if (reset !== 1'b1 || {bus.hist_rd, bus.hist_addr, bus.cdf_out, bus.cdf_valid, bus.bin_idx, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs reset=%0b rd=%0b addr=%0d cdf=%0d valid=%0b idx=%0d busy=%0b done=%0b exp=all0",
               reset, bus.hist_rd, bus.hist_addr, bus.cdf_out, bus.cdf_valid, bus.bin_idx, busy, done);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != 0 || gd) begin
      errors++;
      $display("FAIL reset_mid_no_done done_pulses=%0d exp=0", done_cnt);
    end
    run_pass(-1, -1, cyc, gd);
    mism = score_pass(fb, g, e);
    checks++;
    if (!gd || cyc != 769 || mism != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL reset_mid_restart done=%0b cycles=%0d mismatches=%0d first_bin=%0d got=%0d exp=%0d",
               gd, cyc, mism, fb, g, e);
    end
  endtask

  task automatic test_start_busy();
    int cyc; bit gd; int mism; int fb; logic [7:0] g; logic [7:0] e;
    for (int i = 0; i < 256; i++) mem[i] = CNT_W'(1024);
    build_expected();
    ds_mode = 0;
    run_pass(50, -1, cyc, gd);
    mism = score_pass(fb, g, e);
    checks++;
    if (!gd || cyc != 769 || mism != 0) begin
      errors++;
      $display("FAIL start_busy_pass done=%0b cycles=%0d mismatches=%0d first_bin=%0d got=%0d exp=%0d",
               gd, cyc, mism, fb, g, e);
    end
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_busy_single_done done_pulses=%0d busy=%0b exp=1/0", done_cnt, busy);
    end
  endtask

  task automatic test_max();
    int cyc; bit gd; int mism; int fb; logic [7:0] g; logic [7:0] e;
    for (int i = 0; i < 256; i++) mem[i] = CNT_W'((1 << 18) - 1);
    build_expected();
    ds_mode = 0;
    run_pass(-1, -1, cyc, gd);
    mism = score_pass(fb, g, e);
    checks++;
    if (!gd || mism != 0) begin
      errors++;
      $display("FAIL max_cdf done=%0b mismatches=%0d first_bin=%0d got=%0d exp=%0d", gd, mism, fb, g, e);
    end
    checks++;
    if (obs_cdf.size() != 256 || obs_cdf[0] !== 8'd255 || obs_cdf[128] !== 8'd255 || obs_cdf[255] !== 8'd255) begin
      errors++;
      $display("FAIL max_points valids=%0d got=%0d,%0d,%0d exp=255", obs_cdf.size(),
               obs_cdf[0], obs_cdf[128], obs_cdf[255]);
    end
  endtask

  task automatic test_random();
    int cyc; bit gd; int mism; int fb; logic [7:0] g; logic [7:0] e; int nz;
    for (int p = 0; p < 3; p++) begin
      nz = $urandom_range(0, 30);
      for (int i = 0; i < 256; i++)
        mem[i] = (i < nz || $urandom_range(0, 3) == 0) ? '0 : CNT_W'($urandom_range(1, 4000));
      build_expected();
      ds_mode = 2;
      run_pass(-1, -1, cyc, gd);
      mism = score_pass(fb, g, e);
      checks++;
      if (!gd || mism != 0 || done_cnt != 1) begin
        errors++;
        $display("FAIL random_pass%0d done=%0b mismatches=%0d first_bin=%0d got=%0d exp=%0d pulses=%0d",
                 p, gd, mism, fb, g, e, done_cnt);
      end
    end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_uniform();
    test_ds_delay();
    test_sparse();
    test_reset_mid();
    test_start_busy();
    test_max();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
